// File: rtl/mul_ram_sched_pkg.sv
// Shared types and constants for the multiply-RAM scheduler.
// RAM map: operand A at 0, operand B at 1, registered product at 2.
package mul_ram_sched_pkg;

  localparam int DW_DEF = 16;
  localparam int PW_DEF = 32;

  localparam logic [1:0] ADDR_A = 2'd0;
  localparam logic [1:0] ADDR_B = 2'd1;
  localparam logic [1:0] ADDR_P = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    RD,
    CAP
  } state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request at or after last+1,
// wrapping around. The pointer register is owned by the caller.
module rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             any
);

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    // k runs 1..N_REQ so the last winner is considered only after everyone else
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req[wrap(last, k)]) begin
        any                   = 1'b1;
        index                 = wrap(last, k);
        grant[wrap(last, k)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_ram_sched.sv
// Round-robin scheduler and sole master of the shared multiply-RAM port.
// state | meaning
// IDLE  | RAM port quiet; arbitrate requests not pulsing done this cycle
// WR_A  | write latched operand A to ADDR_A
// WR_B  | write latched operand B to ADDR_B
// RD    | read strobe at ADDR_P; RAM registers the product at this edge
// CAP   | ram_dout holds the product; capture it and pulse done
module mul_ram_sched
  import mul_ram_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = DW_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] op_a,
  input  logic [N_REQ*DW-1:0] op_b,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [PW-1:0]       result,
  output logic                busy,
  output logic                ram_e,
  output logic                ram_w,
  output logic                ram_r,
  output logic [1:0]          ram_addr,
  output logic [DW-1:0]       ram_din,
  input  logic [PW-1:0]       ram_dout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state, state_nxt;
  logic [IW-1:0]     last;
  logic [DW-1:0]     a_q, b_q;
  logic [DW-1:0]     sel_a, sel_b;
  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_index;
  logic              arb_any;

  // A requester still seeing its done pulse cannot be re-granted in that cycle
  rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req   (req & ~done),
    .last  (last),
    .grant (arb_grant),
    .index (arb_index),
    .any   (arb_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_index == IW'(i)) begin
        sel_a = op_a[i*DW +: DW];
        sel_b = op_b[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_e     = 1'b1;
    ram_w     = 1'b0;
    ram_r     = 1'b0;
    ram_addr  = ADDR_A;
    ram_din   = '0;
    case (state)
      IDLE: begin
        ram_e = 1'b0;
        if (arb_any) state_nxt = WR_A;
      end
      WR_A: begin
        ram_w     = 1'b1;
        ram_addr  = ADDR_A;
        ram_din   = a_q;
        state_nxt = WR_B;
      end
      WR_B: begin
        ram_w     = 1'b1;
        ram_addr  = ADDR_B;
        ram_din   = b_q;
        state_nxt = RD;
      end
      RD: begin
        ram_r     = 1'b1;
        ram_addr  = ADDR_P;
        state_nxt = CAP;
      end
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last   <= IW'(N_REQ - 1);
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            last <= arb_index;
            gnt  <= arb_grant;
            a_q  <= sel_a;
            b_q  <= sel_b;
          end
        end
        CAP: begin
          result <= ram_dout;
          done   <= gnt;
          gnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mul_ram_sched.md
Name: mul_ram_sched

Overview:
- Schedules the shared multiply-RAM between N_REQ requesters over a req/done handshake.
- Arbitrates round-robin and latches the winner's two 16-bit operands.
- Sequences the RAM port: write operand A to addr 0, write operand B to addr 1, read the 32-bit product from addr 2.
- Returns the product to the winner with a one-cycle done pulse.
- Sits between the compute clients and the multiply-RAM instance; it is the only master of that RAM port.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- DW, 16, operand width; must equal the RAM data-in width.
- PW, 32, product width; must equal the RAM data-out width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester request, level
- op_a  in  N_REQ*DW  flattened multiplicands; requester i uses bits [i*DW +: DW]
- op_b  in  N_REQ*DW  flattened multipliers; same packing as op_a
- gnt  out  N_REQ  one-hot grant, high for the whole transaction
- done  out  N_REQ  one-hot one-cycle pulse; result valid in that cycle
- result  out  PW  product of the last completed transaction; held until the next done
- busy  out  1  high while not in IDLE
- ram_e  out  1  RAM enable; high in every non-IDLE state
- ram_w  out  1  RAM write strobe
- ram_r  out  1  RAM read strobe
- ram_addr  out  2  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  PW  RAM registered read data

Behaviour:
- Reset (rst_n low at a rising edge):
  - state := IDLE; gnt, done, result, busy and all ram_* outputs := 0.
  - Round-robin pointer last := N_REQ-1, so requester 0 has first priority.
- Reset mid-transaction: abort immediately; no done pulse; gnt low after that edge. RAM contents are left as they are.
- IDLE:
  - ram_* are all 0.
  - A requester whose done is high this cycle is masked from arbitration.
  - If any unmasked req is high at an edge:
    - Pick the first requester at or after (last+1) mod N_REQ, wrapping around.
    - Latch its index, op_a slice and op_b slice.
    - Set last := index and gnt[index] := 1; go to WR_A.
- WR_A: ram_w=1, ram_addr=0, ram_din=latched A. Go to WR_B.
- WR_B: ram_w=1, ram_addr=1, ram_din=latched B. Go to RD.
- RD: ram_r=1, ram_addr=2. The RAM registers the product at this edge. Go to CAP.
- CAP:
  - ram_w=0, ram_r=0; ram_dout holds the product.
  - At the edge: result := ram_dout, done[index] := 1, gnt := 0, go to IDLE.
- done lasts exactly one cycle; it is high in the first IDLE cycle after CAP.
- Latency:
  - req sampled high at edge 0 gives gnt high in cycles 1-4 and done plus result in cycle 5.
  - Back-to-back transactions start every 5 cycles.
- Operands are latched at grant; op_a/op_b changes after grant are ignored.
- req dropping mid-transaction is ignored; the transaction completes and done still pulses.
- No internal arithmetic. result is a straight PW-bit copy of ram_dout; no truncation or sign handling (unsigned).
- ram_w and ram_r are never high in the same cycle.
- ram_addr = 3 is never driven.

Decomposition:
- Shared package holds:
  - state enum {IDLE, WR_A, WR_B, RD, CAP};
  - address constants ADDR_A=2'd0, ADDR_B=2'd1, ADDR_P=2'd2;
  - DW/PW defaults.
- One natural sub-module: rr_arb, a combinational round-robin picker.
  - Inputs: req vector (masked), last pointer.
  - Outputs: grant one-hot, index, any.
  - The pointer register lives in mul_ram_sched.

Test Plan:
- Single request: req0=1 with A=3, B=5 at edge 0.
  - RAM writes 3@0 in cycle 1 and 5@1 in cycle 2; read @2 in cycle 3.
  - done[0] and result=15 in cycle 5; gnt[0] high in cycles 1-4.
- Maximum operands: A=16'hFFFF, B=16'hFFFF gives result=32'hFFFE0001. A=0, B=16'h1234 gives result=0.
- Contention: req0 and req1 held high continuously (A0=2/B0=7, A1=4/B1=9).
  - Grants alternate 0,1,0,1; results alternate 14, 36; done every 5 cycles.
  - The same requester is never served twice while the other waits.
- Masking: req1 held high through its done cycle with req0 low.
  - No re-grant in the done cycle; the next grant comes only at the following edge.
  - Exactly one done per grant.
- Reset mid-operation: rst_n low during RD.
  - Next cycle: gnt=0, done=0, busy=0, all ram_* = 0, result=0.
  - The next req0 is served first (pointer reset).
- Operand change after grant: change op_a from 3 to 10 during WR_B. result=15, not 50.
